// File: rtl/ultrasonic_echo_emulator_if.sv
// Trigger/echo bus between a ranging controller (master) and the echo emulator (slave).
interface ultrasonic_echo_emulator_if;
  logic        trigger;
  logic [8:0]  distance_cm;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic [15:0] meas_count;

  modport master (
    output trigger, distance_cm,
    input  echo, busy, trig_err, meas_count
  );

  modport slave (
    input  trigger, distance_cm,
    output echo, busy, trig_err, meas_count
  );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style responder: validates a trigger pulse, waits a launch delay, then emits an echo
// whose width encodes distance_cm. Define US_ECHO_JITTER_EN to add 0..63 cycles of LFSR jitter.
module ultrasonic_echo_emulator #(
  parameter int unsigned CYCLES_PER_CM = 2900,
  parameter int unsigned MIN_TRIG_CYC  = 500,
  parameter int unsigned LAUNCH_DLY    = 10000,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_CYC   = 1900000,
  parameter int unsigned HOLDOFF_CYC   = 500000
) (
  input logic clk,
  input logic reset,
  ultrasonic_echo_emulator_if.slave bus
);

  localparam logic [20:0] MIN_L    = 21'(MIN_TRIG_CYC);
  localparam logic [20:0] MAX_L    = 21'(MAX_CM);
  localparam logic [20:0] LD_LAST  = 21'(LAUNCH_DLY - 1);
  localparam logic [20:0] CPC_LAST = 21'(CYCLES_PER_CM - 1);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYC - 1);
  localparam logic [20:0] HO_LAST  = 21'(HOLDOFF_CYC - 1);

  typedef enum logic [2:0] {IDLE, TRIG, DELAY, ECHO, HOLDOFF} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_sync;
  logic        r_trig_prev;
  logic [20:0] r_trig_cnt;
  logic [20:0] r_cnt;
  logic [8:0]  r_dist;
  logic [8:0]  r_cm;
  logic        r_to;
  logic [5:0]  r_tail;
  logic        r_main_done;
  logic        r_trig_err;
  logic [15:0] r_meas;
  logic        w_err_pulse;
  logic        w_trig_s, w_rise, w_in_range, w_main_last, w_echo_last;
  logic [5:0]  w_jitter;

  assign w_trig_s   = r_sync[1];
  assign w_rise     = w_trig_s & ~r_trig_prev;
  assign w_in_range = (r_dist != 9'd0) && (21'(r_dist) <= MAX_L);

  // Main phase is either cm x sub-cm counting or a flat timeout; the jitter tail follows it.
  assign w_main_last = r_to ? (r_cnt == TO_LAST) : ((r_cnt == CPC_LAST) && (r_cm == 9'd1));
  assign w_echo_last = r_main_done ? (r_tail == 6'd1) : (w_main_last && (r_tail == 6'd0));

`ifdef US_ECHO_JITTER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!reset) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_jitter = r_lfsr[5:0];
`else
  assign w_jitter = 6'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_err_pulse = 1'b0;
    case (r_state)
      IDLE:    if (w_rise) w_next = TRIG;
      TRIG: begin
        if (!w_trig_s) begin
          if (r_trig_cnt >= MIN_L) begin
            w_next = DELAY;
          end else begin
            w_next      = IDLE;
            w_err_pulse = 1'b1;
          end
        end
      end
      DELAY:   if (r_cnt == LD_LAST) w_next = ECHO;
      ECHO:    if (w_echo_last) w_next = HOLDOFF;
      HOLDOFF: if (r_cnt == HO_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync      <= 2'b00;
      r_trig_prev <= 1'b0;
      r_trig_cnt  <= '0;
      r_cnt       <= '0;
      r_dist      <= '0;
      r_cm        <= '0;
      r_to        <= 1'b0;
      r_tail      <= '0;
      r_main_done <= 1'b0;
      r_trig_err  <= 1'b0;
      r_meas      <= '0;
    end else begin
      r_sync      <= {r_sync[0], bus.trigger};
      r_trig_prev <= w_trig_s;
      r_trig_err  <= w_err_pulse;
      case (r_state)
        IDLE: begin
          // The rising cycle already counts as one cycle of trigger-high time.
          if (w_rise) begin
            r_trig_cnt <= 21'd1;
            r_dist     <= bus.distance_cm;
          end
        end
        TRIG: begin
          r_cnt <= '0;
          if (w_trig_s && (r_trig_cnt < MIN_L)) r_trig_cnt <= r_trig_cnt + 21'd1;
        end
        DELAY: begin
          if (r_cnt == LD_LAST) begin
            r_cnt       <= '0;
            r_cm        <= r_dist;
            r_to        <= ~w_in_range;
            r_tail      <= w_jitter;
            r_main_done <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end
        ECHO: begin
          if (w_echo_last) begin
            r_cnt  <= '0;
            r_meas <= r_meas + 16'd1;
          end else if (r_main_done) begin
            r_tail <= r_tail - 6'd1;
          end else if (w_main_last) begin
            r_main_done <= 1'b1;
          end else if (!r_to && (r_cnt == CPC_LAST)) begin
            r_cnt <= '0;
            r_cm  <= r_cm - 9'd1;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end
        HOLDOFF: r_cnt <= r_cnt + 21'd1;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.echo       = (r_state == ECHO);
  assign bus.busy       = (r_state != IDLE);
  assign bus.trig_err   = r_trig_err;
  assign bus.meas_count = r_meas;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed and randomized bench for ultrasonic_echo_emulator with scaled-down timing parameters.
module tb_ultrasonic_echo_emulator;
  localparam int CPC      = 10;
  localparam int MIN_TRIG = 5;
  localparam int LD       = 20;
  localparam int MAXCM    = 400;
  localparam int TO       = 5000;
  localparam int HO       = 50;
  localparam int SYNC_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int assertCount = 0;
  int failCount   = 0;
  int errPulses   = 0;
  int expMeas     = 0;

  always #5 clk = ~clk;

  ultrasonic_echo_emulator_if bus();

  ultrasonic_echo_emulator #(
    .CYCLES_PER_CM(CPC), .MIN_TRIG_CYC(MIN_TRIG), .LAUNCH_DLY(LD),
    .MAX_CM(MAXCM), .TIMEOUT_CYC(TO), .HOLDOFF_CYC(HO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always @(negedge clk) if (bus.trig_err === 1'b1) errPulses++;

  // Expected echo width straight from the distance rules.
  function automatic int expWidth(input int d);
    return (d >= 1 && d <= MAXCM) ? d * CPC : TO;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int hi);
    bus.trigger = 1'b1;
    repeat (hi) step();
    bus.trigger = 1'b0;
  endtask

  task automatic errTrigger(input string tag, input int hi);
    int errBefore;
    int sawEcho;
    errBefore = errPulses;
    sawEcho   = 0;
    applyStimulus(hi);
    repeat (10) begin
      step();
      if (bus.echo !== 1'b0) sawEcho++;
    end
    checkOutput({tag, " errPulse"}, errPulses - errBefore, 1);
    checkOutput({tag, " noEcho"}, sawEcho, 0);
    checkOutput({tag, " idle"}, bus.busy, 0);
    checkOutput({tag, " meas"}, bus.meas_count, expMeas & 16'hFFFF);
  endtask

  // mode 0: plain pulse; 1: extra triggers + distance change + held trigger; 2: reset at echo cycle 100
  task automatic runPulse(input string tag, input int d, input int hi, input int mode);
    int rise, w, n, errBefore, dly;
    errBefore = errPulses;
    bus.distance_cm = 9'(d);
    applyStimulus(hi);
    rise = 0;
    while (bus.echo !== 1'b1 && rise < 20000) begin
      step();
      rise++;
    end
    checkOutput({tag, " riseDelay"}, rise, SYNC_LAT + LD + 1);
    w = 0;
    while (bus.echo === 1'b1 && w < 10000) begin
      w++;
      if (mode == 1) begin
        if (w == 50) bus.trigger = 1'b1;
        if (w == 60) bus.trigger = 1'b0;
        if (w == 80) bus.distance_cm = 9'(d + 77);
      end
      if (mode == 2 && w == 100) begin
        reset = 1'b0;
        step();
        checkOutput({tag, " rstEcho"}, bus.echo, 0);
        checkOutput({tag, " rstBusy"}, bus.busy, 0);
        checkOutput({tag, " rstMeas"}, bus.meas_count, 0);
        reset   = 1'b1;
        expMeas = 0;
        return;
      end
      step();
    end
    checkOutput({tag, " width"}, w, expWidth(d));
    expMeas = (expMeas + 1) & 16'hFFFF;
    checkOutput({tag, " meas"}, bus.meas_count, expMeas);
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      if (mode == 1) begin
        if (n == 10) bus.trigger = 1'b1;
        if (n == 20) bus.trigger = 1'b0;
        if (n == 40) bus.trigger = 1'b1;
      end
      step();
      n++;
    end
    checkOutput({tag, " holdoff"}, n, HO);
    checkOutput({tag, " noErr"}, errPulses - errBefore, 0);
    if (mode == 1) begin
      dly = 0;
      repeat (10) begin
        step();
        if (bus.busy !== 1'b0) dly++;
      end
      bus.trigger = 1'b0;
      repeat (10) begin
        step();
        if (bus.busy !== 1'b0) dly++;
      end
      checkOutput({tag, " heldTrigIgnored"}, dly, 0);
      checkOutput({tag, " singleCount"}, bus.meas_count, expMeas);
    end
  endtask

  initial begin
    int d, hi;
    reset           = 1'b0;
    bus.trigger     = 1'b0;
    bus.distance_cm = 9'd0;
    repeat (3) step();
    checkOutput("reset echo", bus.echo, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset trigErr", bus.trig_err, 0);
    checkOutput("reset meas", bus.meas_count, 0);
    reset = 1'b1;
    repeat (2) step();

    $display("[TB] basic pulse");
    runPulse("t1", 25, 8, 0);

    $display("[TB] short triggers");
    errTrigger("t2 short3", 3);
    errTrigger("t2 short4", MIN_TRIG - 1);
    runPulse("t2 after", 25, 8, 0);
    runPulse("t2 minTrig", 7, MIN_TRIG, 0);

    $display("[TB] range limits");
    runPulse("t3 d0", 0, 8, 0);
    runPulse("t3 d450", 450, 8, 0);
    runPulse("t3 d400", 400, 8, 0);
    runPulse("t3 d1", 1, 8, 0);

    $display("[TB] triggers while busy");
    runPulse("t4 disturb", 30, 8, 1);

    $display("[TB] randomized pulses");
    for (int i = 0; i < 6; i++) begin
      d  = int'($urandom_range(1, 60));
      hi = int'($urandom_range(MIN_TRIG, 12));
      runPulse($sformatf("rand%0d", i), d, hi, 0);
      errTrigger($sformatf("randErr%0d", i), int'($urandom_range(1, MIN_TRIG - 1)));
    end

    $display("[TB] reset mid-echo");
    runPulse("t5 rst", 40, 8, 2);
    repeat (3) step();
    runPulse("t5 after", 40, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
